// File: rtl/inst_assembler_if.sv
// Beat-in / instruction-out handshake bundle for inst_assembler.
// master drives beats and consumes instructions; slave is the assembler side.
interface inst_assembler_if #(
    parameter int unsigned BITS  = 8,
    parameter int unsigned WORDS = 2
);
    logic [BITS-1:0]       in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic [BITS*WORDS-1:0] inst;
    logic                  inst_valid;
    logic                  inst_ready;

    modport master (
        output in_data, in_valid, inst_ready,
        input  in_ready, inst, inst_valid
    );

    modport slave (
        input  in_data, in_valid, inst_ready,
        output in_ready, inst, inst_valid
    );
endinterface

// File: rtl/inst_assembler.sv
// Packs WORDS beats MSB-first into one instruction and queues it in a DEPTH-entry FIFO.
// Optional partial-instruction idle timeout enabled by INST_ASM_TIMEOUT_EN.
module inst_assembler #(
    parameter int unsigned BITS    = 8,
    parameter int unsigned WORDS   = 2,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 256
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    inst_assembler_if.slave                          bus,
    input  logic                                     flush,
    output logic [$clog2(WORDS > 2 ? WORDS : 2)-1:0] beat_cnt,
    output logic [$clog2(DEPTH + 1)-1:0]             level,
    output logic                                     timeout_err
);
    localparam int unsigned W  = BITS * WORDS;
    localparam int unsigned PW = BITS * (WORDS - 1);
    localparam int unsigned CW = $clog2(WORDS > 2 ? WORDS : 2);
    localparam int unsigned LW = $clog2(DEPTH + 1);
    localparam int unsigned AW = $clog2(DEPTH > 2 ? DEPTH : 2);
    localparam logic [CW-1:0] LastBeat = CW'(WORDS - 1);
    localparam logic [LW-1:0] Full     = LW'(DEPTH);
    localparam logic [AW-1:0] LastPtr  = AW'(DEPTH - 1);

    logic [CW-1:0] beat_q, beat_d;
    logic [PW-1:0] part_q, part_d;  // top WORDS-1 slices; the last beat goes straight to the FIFO
    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [LW-1:0] level_q, level_d;
    logic          ready, accept, push, pop;
    logic [W-1:0]  word;

`ifdef INST_ASM_TIMEOUT_EN
    localparam int unsigned IW = $clog2(TIMEOUT + 1);
    logic [IW-1:0] idle_q, idle_d;
    logic          err_q, err_d;
`endif

    assign ready          = (beat_q != LastBeat) || (level_q != Full);
    assign bus.in_ready   = ready;
    assign bus.inst_valid = (level_q != '0);
    assign bus.inst       = mem_q[rd_q];
    assign beat_cnt       = beat_q;
    assign level          = level_q;
    assign word           = {part_q, bus.in_data};

    always_comb begin
        beat_d  = beat_q;
        part_d  = part_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        level_d = level_q;
        accept  = 1'b0;
        push    = 1'b0;
        pop     = 1'b0;
`ifdef INST_ASM_TIMEOUT_EN
        idle_d  = idle_q;
        err_d   = 1'b0;
`endif
        if (flush) begin
            beat_d  = '0;
            wr_d    = '0;
            rd_d    = '0;
            level_d = '0;
`ifdef INST_ASM_TIMEOUT_EN
            idle_d  = '0;
`endif
        end else begin
            accept = bus.in_valid && ready;
            pop    = bus.inst_valid && bus.inst_ready;
            if (accept) begin
                if (beat_q == LastBeat) begin
                    beat_d = '0;
                    push   = 1'b1;
                end else begin
                    beat_d = beat_q + 1'b1;
                    for (int unsigned k = 0; k < WORDS - 1; k++) begin
                        if (beat_q == CW'(k)) part_d[BITS*(WORDS-2-k) +: BITS] = bus.in_data;
                    end
                end
            end
            if (push) wr_d = (wr_q == LastPtr) ? '0 : wr_q + 1'b1;
            if (pop)  rd_d = (rd_q == LastPtr) ? '0 : rd_q + 1'b1;
            unique case ({push, pop})
                2'b10:   level_d = level_q + 1'b1;
                2'b01:   level_d = level_q - 1'b1;
                default: level_d = level_q;
            endcase
`ifdef INST_ASM_TIMEOUT_EN
            // An accepted beat on the expiry edge wins over the discard.
            if (accept || beat_q == '0) begin
                idle_d = '0;
            end else if (idle_q == IW'(TIMEOUT - 1)) begin
                idle_d = '0;
                beat_d = '0;
                err_d  = 1'b1;
            end else begin
                idle_d = idle_q + 1'b1;
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_q  <= '0;
            part_q  <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
        end else begin
            beat_q  <= beat_d;
            part_q  <= part_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            level_q <= level_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (push) begin
            mem_q[wr_q] <= word;
        end
    end

`ifdef INST_ASM_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_q <= '0;
            err_q  <= 1'b0;
        end else begin
            idle_q <= idle_d;
            err_q  <= err_d;
        end
    end

    assign timeout_err = err_q;
`else
    assign timeout_err = 1'b0;
`endif
endmodule

// File: tb/tb_inst_assembler.sv
// Randomized bench for inst_assembler against a queue-based reference model.
// Follows INST_ASM_TIMEOUT_EN the same way as the design.
module tb_inst_assembler;
    localparam int unsigned BITS    = 8;
    localparam int unsigned WORDS   = 2;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned TIMEOUT = 16;
    localparam int unsigned W       = BITS * WORDS;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic       flush = 1'b0;
    logic [0:0] beat_cnt;
    logic [2:0] level;
    logic       timeout_err;

    inst_assembler_if #(.BITS(BITS), .WORDS(WORDS)) bus ();

    inst_assembler #(
        .BITS   (BITS),
        .WORDS  (WORDS),
        .DEPTH  (DEPTH),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .flush      (flush),
        .beat_cnt   (beat_cnt),
        .level      (level),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // Reference model: beats of the partial instruction and the queued words.
    logic [BITS-1:0] m_part[$];
    logic [W-1:0]    m_fifo[$];
    int              m_idle;
    logic            m_err;
    int              n_vec = 0;
    int              n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic model_ready();
        return !(m_part.size() == WORDS - 1 && m_fifo.size() == DEPTH);
    endfunction

    task automatic model_clear();
        m_part.delete();
        m_fifo.delete();
        m_idle = 0;
        m_err  = 1'b0;
    endtask

    task automatic check_state(input string tag);
        check({tag, ".beat_cnt"}, 32'(beat_cnt), m_part.size());
        check({tag, ".level"}, 32'(level), m_fifo.size());
        check({tag, ".in_ready"}, 32'(bus.in_ready), 32'(model_ready()));
        check({tag, ".inst_valid"}, 32'(bus.inst_valid), 32'(m_fifo.size() != 0));
        if (m_fifo.size() != 0) check({tag, ".inst"}, 32'(bus.inst), 32'(m_fifo[0]));
        check({tag, ".timeout_err"}, 32'(timeout_err), 32'(m_err));
    endtask

    // Apply one cycle of inputs, advance the model, then check after the edge.
    task automatic cycle(input logic v, input logic [BITS-1:0] d, input logic r, input logic f,
                         input string tag);
        logic       acc;
        logic [W-1:0] w;
        int         had;
        bus.in_valid   = v;
        bus.in_data    = d;
        bus.inst_ready = r;
        flush          = f;
        had   = m_part.size();
        m_err = 1'b0;
        if (f) begin
            m_part.delete();
            m_fifo.delete();
            m_idle = 0;
        end else begin
            acc = v && model_ready();
            if (r && m_fifo.size() != 0) void'(m_fifo.pop_front());
            if (acc) begin
                m_part.push_back(d);
                if (m_part.size() == WORDS) begin
                    w = '0;
                    foreach (m_part[i]) w = (w << BITS) | W'(m_part[i]);
                    m_fifo.push_back(w);
                    m_part.delete();
                end
            end
`ifdef INST_ASM_TIMEOUT_EN
            if (acc || had == 0) begin
                m_idle = 0;
            end else begin
                m_idle++;
                if (m_idle == TIMEOUT) begin
                    m_idle = 0;
                    m_part.delete();
                    m_err = 1'b1;
                end
            end
`endif
        end
        @(posedge clk);
        #1;
        check_state(tag);
    endtask

    task automatic push_word(input logic [W-1:0] w, input string tag);
        cycle(1'b1, w[W-1 -: BITS], 1'b0, 1'b0, tag);
        cycle(1'b1, w[BITS-1:0], 1'b0, 1'b0, tag);
    endtask

    initial begin
        int pv, pr;
        logic [W-1:0] w;
        bus.in_data    = '0;
        bus.in_valid   = 1'b0;
        bus.inst_ready = 1'b0;
        model_clear();

        #2 rst_n = 1'b0;
        #1;
        check("rst.beat_cnt", 32'(beat_cnt), 0);
        check("rst.level", 32'(level), 0);
        check("rst.inst_valid", 32'(bus.inst_valid), 0);
        check("rst.inst", 32'(bus.inst), 0);
        check("rst.timeout_err", 32'(timeout_err), 0);
        @(negedge clk) rst_n = 1'b1;
        #1;
        check("rst.in_ready", 32'(bus.in_ready), 1);

        // Back-to-back beats form 0x1234, visible one cycle later.
        cycle(1'b1, 8'h12, 1'b0, 1'b0, "pack.b0");
        cycle(1'b1, 8'h34, 1'b0, 1'b0, "pack.b1");
        check("pack.inst", 32'(bus.inst), 32'h1234);
        check("pack.level", 32'(level), 1);

        // Reset mid-stream takes effect before the next clock edge.
        cycle(1'b1, 8'hAB, 1'b0, 1'b0, "midrst.beat");
        #1 rst_n = 1'b0;
        #1;
        check("midrst.beat_cnt", 32'(beat_cnt), 0);
        check("midrst.level", 32'(level), 0);
        check("midrst.inst_valid", 32'(bus.inst_valid), 0);
        model_clear();
        @(negedge clk) rst_n = 1'b1;

        // Fill, stall the completing beat, then pop and drain in order.
        for (int i = 0; i < DEPTH; i++) push_word(W'(16'hA100 + 16'h0111 * i), "fill");
        check("full.level", 32'(level), DEPTH);
        cycle(1'b1, 8'h55, 1'b0, 1'b0, "full.first");
        check("full.beat_cnt", 32'(beat_cnt), 1);
        check("full.in_ready", 32'(bus.in_ready), 0);
        cycle(1'b1, 8'h66, 1'b1, 1'b0, "full.pop");
        check("full.ready_after_pop", 32'(bus.in_ready), 1);
        cycle(1'b1, 8'h66, 1'b0, 1'b0, "full.complete");
        check("full.level_back", 32'(level), DEPTH);
        for (int i = 0; i < DEPTH; i++) cycle(1'b0, '0, 1'b1, 1'b0, "drain");
        check("drain.level", 32'(level), 0);

        // Completing beat and pop on the same edge at level 2.
        push_word(16'h1111, "pp.w0");
        push_word(16'h2222, "pp.w1");
        cycle(1'b1, 8'h33, 1'b0, 1'b0, "pp.hi");
        cycle(1'b1, 8'h44, 1'b1, 1'b0, "pp.lo_pop");
        check("pp.level", 32'(level), 2);
        check("pp.head", 32'(bus.inst), 32'h2222);

        // Flush with an in-flight beat.
        push_word(16'hBEEF, "fl.w");
        cycle(1'b1, 8'h9A, 1'b0, 1'b0, "fl.partial");
        check("fl.pre_level", 32'(level), 3);
        cycle(1'b1, 8'hBC, 1'b1, 1'b1, "fl.flush");
        check("fl.beat_cnt", 32'(beat_cnt), 0);
        check("fl.inst_valid", 32'(bus.inst_valid), 0);

        // Idle partial instruction: discarded only with the timeout enabled.
        cycle(1'b1, 8'h77, 1'b0, 1'b0, "to.beat");
        for (int i = 0; i < TIMEOUT; i++) cycle(1'b0, '0, 1'b0, 1'b0, "to.idle");
`ifdef INST_ASM_TIMEOUT_EN
        check("to.beat_cnt", 32'(beat_cnt), 0);
        check("to.err", 32'(timeout_err), 1);
        cycle(1'b0, '0, 1'b0, 1'b0, "to.after");
        check("to.err_once", 32'(timeout_err), 0);
        cycle(1'b1, 8'h77, 1'b0, 1'b0, "to2.beat");
`else
        check("to.beat_cnt", 32'(beat_cnt), 1);
        check("to.err", 32'(timeout_err), 0);
`endif
        for (int i = 0; i < TIMEOUT - 1; i++) cycle(1'b0, '0, 1'b0, 1'b0, "to2.idle");
        cycle(1'b1, 8'h88, 1'b0, 1'b0, "to2.save");
        check("to2.inst", 32'(bus.inst), 32'h7788);

        // Randomized phases with varying offer/consume bias.
        for (int p = 0; p < 20; p++) begin
            pv = $urandom_range(0, 4);
            pr = $urandom_range(0, 4);
            for (int i = 0; i < 150; i++) begin
                w = W'($urandom);
                cycle($urandom_range(0, 3) < pv, w[BITS-1:0], $urandom_range(0, 3) < pr,
                      $urandom_range(0, 99) == 0, "rand");
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
